// File: rtl/tmr_driver_bank.sv
// Bank of triple-modular-redundant discrete-output drivers.
// Each channel votes three lanes, latches persistent lane faults, and glitch-filters the vote onto DO.
module tmr_driver_bank #(
    parameter int CHANNELS      = 4,
    parameter int FILTER_CYCLES = 3,
    parameter int FAULT_CYCLES  = 8
) (
    input  logic                  SIM_CLK,
    input  logic                  SIM_RST,
    input  logic [CHANNELS-1:0]   DOR_A,
    input  logic [CHANNELS-1:0]   DOR_B,
    input  logic [CHANNELS-1:0]   DOR_C,
    input  logic                  FAULT_CLR,
    output logic [CHANNELS-1:0]   DO,
    output logic [3*CHANNELS-1:0] LANE_FAULT,
    output logic [CHANNELS-1:0]   DISAGREE,
    output logic [CHANNELS-1:0]   CH_FAIL
);

    localparam int FLW = (FILTER_CYCLES < 2) ? 1 : $clog2(FILTER_CYCLES + 1);
    localparam int FCW = $clog2(FAULT_CYCLES + 1);
    localparam logic [FLW-1:0] FILT_LAST  = FLW'(FILTER_CYCLES - 1);
    localparam logic [FCW-1:0] FAULT_LAST = FCW'(FAULT_CYCLES - 1);
    localparam logic [FCW-1:0] FAULT_MAX  = FCW'(FAULT_CYCLES);

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
        logic [2:0]     lane;
        logic           maj;
        logic [2:0]     flt_q, flt_d;
        logic [FCW-1:0] cnt_q [3];
        logic [FCW-1:0] cnt_d [3];
        logic           vote, vote_ok;
        logic           dis_q, dis_d, fail_q, fail_d;
        logic           do_q, do_d;
        logic [FLW-1:0] fcnt_q, fcnt_d;

        assign lane = {DOR_C[ch], DOR_B[ch], DOR_A[ch]};
        assign maj  = (lane[0] & lane[1]) | (lane[0] & lane[2]) | (lane[1] & lane[2]);

        always_comb begin
            vote    = maj;
            vote_ok = 1'b1;
            dis_d   = 1'b0;
            fail_d  = 1'b0;
            // One faulted lane: the remaining pair must agree to produce a vote.
            case (flt_q)
                3'b000: ;
                3'b001: begin vote = lane[1]; vote_ok = (lane[1] == lane[2]); end
                3'b010: begin vote = lane[0]; vote_ok = (lane[0] == lane[2]); end
                3'b100: begin vote = lane[0]; vote_ok = (lane[0] == lane[1]); end
                default: begin vote_ok = 1'b0; fail_d = 1'b1; end
            endcase
            if (flt_q == 3'b001 || flt_q == 3'b010 || flt_q == 3'b100)
                dis_d = !vote_ok;

            for (int l = 0; l < 3; l++) begin
                flt_d[l] = flt_q[l];
                cnt_d[l] = '0;
                if (lane[l] != maj) begin
                    if (cnt_q[l] >= FAULT_LAST) begin
                        cnt_d[l] = FAULT_MAX;
                        flt_d[l] = 1'b1;
                    end else begin
                        cnt_d[l] = cnt_q[l] + 1'b1;
                    end
                end
                if (FAULT_CLR) begin
                    cnt_d[l] = '0;
                    flt_d[l] = 1'b0;
                end
            end
            if (FAULT_CLR) begin
                dis_d  = 1'b0;
                fail_d = 1'b0;
            end

            do_d   = do_q;
            fcnt_d = '0;
            if (vote_ok && (vote != do_q)) begin
                if (fcnt_q == FILT_LAST)
                    do_d = vote;
                else
                    fcnt_d = fcnt_q + 1'b1;
            end
        end

        always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
            if (!SIM_RST) begin
                flt_q  <= '0;
                dis_q  <= 1'b0;
                fail_q <= 1'b0;
                do_q   <= 1'b0;
                fcnt_q <= '0;
                for (int l = 0; l < 3; l++) cnt_q[l] <= '0;
            end else begin
                flt_q  <= flt_d;
                dis_q  <= dis_d;
                fail_q <= fail_d;
                do_q   <= do_d;
                fcnt_q <= fcnt_d;
                for (int l = 0; l < 3; l++) cnt_q[l] <= cnt_d[l];
            end
        end

        assign DO[ch]               = do_q;
        assign LANE_FAULT[3*ch +: 3] = flt_q;
        assign DISAGREE[ch]         = dis_q;
        assign CH_FAIL[ch]          = fail_q;
    end

endmodule

// File: doc/tmr_driver_bank.md
# tmr_driver_bank

Parametrised bank of triple-modular-redundant discrete-output drivers for the LVDA simulation. Each of `CHANNELS` outputs votes three redundant lane inputs, tracks persistent per-lane miscompares as sticky lane faults, and degrades to two-lane voting or a frozen failsafe as lanes fail. A persistence filter on the voted value suppresses short glitches before the `DO` output. It replaces fixed per-signal driver instances with one configurable bank.

## Interface
- `CHANNELS`, default 4: number of discrete outputs.
- `FILTER_CYCLES`, default 3, minimum 1: number of consecutive cycles the voted value must differ from `DO` before `DO` follows it.
- `FAULT_CYCLES`, default 8, minimum 1: number of consecutive cycles a lane must miscompare before its fault flag sets.

Ports (clock and reset first):
- `SIM_CLK`  in  1  sole clock; all state updates on the rising edge.
- `SIM_RST`  in  1  asynchronous, active-low reset.
- `DOR_A`  in  CHANNELS  lane A inputs, synchronous to `SIM_CLK`.
- `DOR_B`  in  CHANNELS  lane B inputs.
- `DOR_C`  in  CHANNELS  lane C inputs.
- `FAULT_CLR`  in  1  synchronous pulse; clears all fault state.
- `DO`  out  CHANNELS  filtered, voted discrete outputs.
- `LANE_FAULT`  out  3*CHANNELS  sticky fault flags; bits {3ch+2, 3ch+1, 3ch} are lanes {C, B, A} of channel ch.
- `DISAGREE`  out  CHANNELS  registered; the channel's two healthy lanes disagree this cycle.
- `CH_FAIL`  out  CHANNELS  registered; two or more lanes of the channel are faulted.

## Operation
Everything below applies per channel, and all channels are independent.

Miscompare detection:
- `M` = raw 2-of-3 majority of A, B and C. `M` ignores fault flags.
- A lane miscompares when its input ≠ `M`. For 1-bit inputs, at most one lane miscompares per cycle.

Fault counters:
- Each lane has a miscompare counter of width `$clog2(FAULT_CYCLES+1)`.
- The counter increments on a miscompare and resets to 0 on a match.
- When the counter reaches `FAULT_CYCLES`, the lane's `LANE_FAULT` bit sets and the counter saturates.
- Flags are sticky and clear only on `FAULT_CLR` or reset.
- A faulted lane keeps counting, but this has no further effect.

Voted value `V` and its validity:
- 0 faulted lanes: `V` = `M`, valid.
- 1 faulted lane: if the two healthy lanes agree, `V` = their value, valid. Otherwise `V` is invalid and `DISAGREE` = 1.
- ≥2 faulted lanes: `V` is invalid and `CH_FAIL` = 1. `DO` is frozen at its current value.

Output filter:
- The filter counter increments each edge where `V` is valid and `V` ≠ `DO`.
- The counter resets to 0 when `V` = `DO` or `V` is invalid.
- On the edge where the counter would reach `FILTER_CYCLES`, `DO` <= `V` and the counter resets to 0.

`FAULT_CLR`:
- On the edge where it is sampled high, it clears all `LANE_FAULT` flags, all miscompare counters, `DISAGREE` and `CH_FAIL`.
- It takes priority over any increment or flag set on the same edge.
- It does not affect `DO` or the filter counters.

Reset (`SIM_RST` low, asynchronous, at any time including mid-filter or mid-count):
- `DO`, `LANE_FAULT`, `DISAGREE`, `CH_FAIL` = 0.
- All counters = 0.

## Timing
- Inputs are sampled on every rising edge. There are no input synchronisers; inputs are already in the `SIM_CLK` domain.
- Clean transition latency: if all lanes change before edge 1 and stay stable, `DO` changes on edge `FILTER_CYCLES`. With `FILTER_CYCLES` = 1, `DO` is simply the registered vote.
- A vote change lasting fewer than `FILTER_CYCLES` consecutive edges never reaches `DO`.
- Fault latency: a lane miscompare sampled on edges 1..`FAULT_CYCLES` sets `LANE_FAULT` on edge `FAULT_CYCLES`. Two-lane voting takes effect from the next edge.
- `DISAGREE` and `CH_FAIL` are registered and reflect the inputs and fault state sampled on the same edge.
- `V` going invalid mid-filter zeroes the filter counter; a full `FILTER_CYCLES` run is needed again once `V` is valid.
- Release of `SIM_RST` is synchronous to the design; the first active edge follows the release.

## Test plan
1. **Reset mid-operation:** drive `SIM_RST` low mid-filter with fault flags set -> `DO`, `LANE_FAULT`, `DISAGREE` and `CH_FAIL` are all 0 immediately, without waiting for a clock edge.
2. **Filter, `FILTER_CYCLES` = 3:**
   - All lanes of ch0 go 0→1 -> `DO[0]` rises on edge 3.
   - A 2-cycle all-lane pulse -> `DO[0]` stays 0.
3. **Fault persistence, `FAULT_CYCLES` = 8:**
   - Lane B of ch1 held opposite to A/C for 8 edges -> `DO[1]` follows A/C; `LANE_FAULT[4]` sets on edge 8.
   - A 7-edge miscompare followed by a match -> no fault flag.
4. **Two-lane disagreement:** with ch1 lane B faulted, set A=1, C=0 -> `DISAGREE[1]` = 1, `DO[1]` holds and its filter counter stays 0. Restore A=C -> `DISAGREE[1]` = 0.
5. **Failsafe and clear:**
   - Fault lanes B then C of ch2 -> `CH_FAIL[2]` = 1 and `DO[2]` is frozen under any input.
   - Pulse `FAULT_CLR` -> all flags are 0 on the next edge and 3-lane voting resumes.
6. **Clear priority:** `FAULT_CLR` asserted on the same edge as a lane's 8th miscompare -> `LANE_FAULT` stays 0 and the counter is 0. Continued miscompares set the fault 8 edges later.
